// File: rtl/adder_ff_unit.sv
// ---------------------------------------------------------------------------
// adder_ff_unit
//
// Registered adder leaf: computes a_in + b_in + cin_in at WIDTH+1 bits and
// captures the result in flops on every rising clock edge (one-cycle latency,
// no enable, no handshake). All outputs come straight from flops, so there is
// no combinational path from any input to any output.
//
// Build option:
//   ADDER_FF_OVF_EN  when defined, adds the ovf_ff port and its flop, which
//                    carries the two's-complement overflow of a_in+b_in+cin_in.
//                    When undefined, the port and flop are absent and
//                    sum_ff/cout_ff behave the same way.
//
// Parameters:
//   WIDTH    operand and sum width in bits (>= 1), default 4
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset, clears all outputs
//   a_in     in   WIDTH  operand A, unsigned
//   b_in     in   WIDTH  operand B, unsigned
//   cin_in   in   1      carry-in
//   sum_ff   out  WIDTH  registered sum, modulo 2^WIDTH
//   cout_ff  out  1      registered carry-out (bit WIDTH of the full sum)
//   ovf_ff   out  1      registered signed overflow (ADDER_FF_OVF_EN only)
// ---------------------------------------------------------------------------
module adder_ff_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic [WIDTH-1:0] sum_ff,
`ifdef ADDER_FF_OVF_EN
    output logic             cout_ff,
    output logic             ovf_ff
`else
    output logic             cout_ff
`endif
);

    // Operands and carry-in are zero-extended to WIDTH+1 bits so the carry
    // out of the top bit lands in sum_full[WIDTH] instead of being dropped.
    logic [WIDTH:0] sum_full;

    assign sum_full = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ff  <= '0;
            cout_ff <= 1'b0;
        end else begin
            sum_ff  <= sum_full[WIDTH-1:0];
            cout_ff <= sum_full[WIDTH];
        end
    end

`ifdef ADDER_FF_OVF_EN
    // Signed overflow is only possible when both operands share a sign; it
    // shows up as the result sign differing from that shared operand sign.
    // The carry-in is already folded into sum_full, so it is covered too.
    logic ovf_next;

    assign ovf_next = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                      (sum_full[WIDTH-1] != a_in[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_ff <= 1'b0;
        end else begin
            ovf_ff <= ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_adder_ff_unit.sv
module tb_adder_ff_unit;

    localparam int WIDTH = 4;
    localparam int SEED  = 32'h1ADD_5EED;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [WIDTH-1:0] sum_ff;
    logic             cout_ff;
`ifdef ADDER_FF_OVF_EN
    logic             ovf_ff;
`endif

    always #5 clk = ~clk;

    adder_ff_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .sum_ff  (sum_ff),
`ifdef ADDER_FF_OVF_EN
        .cout_ff (cout_ff),
        .ovf_ff  (ovf_ff)
`else
        .cout_ff (cout_ff)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic check_model(input string tag, input int a, input int b, input int c);
        int total;
        int sa, sb, ssum;
        total = a + b + c;
        chk({tag, "_sum"},  {28'd0, sum_ff}, total % (1 << WIDTH));
        chk({tag, "_cout"}, {31'd0, cout_ff}, (total >= (1 << WIDTH)) ? 1 : 0);
`ifdef ADDER_FF_OVF_EN
        sa   = (a >= (1 << (WIDTH-1))) ? a - (1 << WIDTH) : a;
        sb   = (b >= (1 << (WIDTH-1))) ? b - (1 << WIDTH) : b;
        ssum = sa + sb + c;
        chk({tag, "_ovf"}, {31'd0, ovf_ff},
            (ssum > (1 << (WIDTH-1)) - 1 || ssum < -(1 << (WIDTH-1))) ? 1 : 0);
`endif
    endtask

    task automatic drive(input int a, input int b, input int c);
        a_in   = a[WIDTH-1:0];
        b_in   = b[WIDTH-1:0];
        cin_in = c[0];
    endtask

    // Drive inputs, take one edge, sample 1 time unit after it.
    task automatic apply(input int a, input int b, input int c);
        drive(a, b, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ra, rb, rc;
        ra = $urandom(SEED);

        rst_n = 1'b1;
        drive(9, 9, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_now_sum",  {28'd0, sum_ff}, 0);
        chk("rst_now_cout", {31'd0, cout_ff}, 0);
`ifdef ADDER_FF_OVF_EN
        chk("rst_now_ovf",  {31'd0, ovf_ff}, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_sum",  {28'd0, sum_ff}, 0);
        chk("rst_hold_cout", {31'd0, cout_ff}, 0);

        rst_n = 1'b1;
        apply(3, 4, 0);
        check_model("basic", 3, 4, 0);

        apply(15, 15, 1);
        check_model("wrap_max", 15, 15, 1);
        apply(8, 8, 0);
        check_model("wrap_8p8", 8, 8, 0);
        apply(0, 0, 0);
        check_model("zero", 0, 0, 0);

        apply(1, 1, 0);
        chk("lat_2", {28'd0, sum_ff}, 2);
        drive(2, 2, 0);
        #2;
        chk("lat_hold_2", {28'd0, sum_ff}, 2);
        @(posedge clk);
        #1;
        chk("lat_4", {28'd0, sum_ff}, 4);
        drive(5, 5, 0);
        #2;
        chk("lat_hold_4", {28'd0, sum_ff}, 4);
        @(posedge clk);
        #1;
        chk("lat_10", {28'd0, sum_ff}, 10);

        // Pulse reset low between edges, release before the next edge.
        drive(6, 3, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",  {28'd0, sum_ff}, 0);
        chk("mid_rst_cout", {31'd0, cout_ff}, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("resume", 6, 3, 0);

        // Reset held low across an edge discards that edge's capture.
        drive(12, 9, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_edge_sum",  {28'd0, sum_ff}, 0);
        chk("rst_edge_cout", {31'd0, cout_ff}, 0);
        rst_n = 1'b1;
        apply(12, 9, 1);
        check_model("after_rst", 12, 9, 1);

`ifdef ADDER_FF_OVF_EN
        apply(7, 1, 0);
        chk("ovf_7p1", {31'd0, ovf_ff}, 1);
        apply(8, 15, 0);
        chk("ovf_neg", {31'd0, ovf_ff}, 1);
        apply(8, 15, 1);
        chk("ovf_neg_cin", {31'd0, ovf_ff}, 0);
`endif

        for (int i = 0; i < 500; i++) begin
            ra = int'($urandom_range(0, (1 << WIDTH) - 1));
            rb = int'($urandom_range(0, (1 << WIDTH) - 1));
            rc = int'($urandom_range(0, 1));
            apply(ra, rb, rc);
            check_model("rand", ra, rb, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
